cluster_pwr_iso_ctrl: RTL

Sequencer that drives the output-isolation clamps, clock gate, reset and power switch of one switchable cluster power domain. It sits in the always-on domain and runs fixed power-up and power-down sequences on a level request. Its single clamp output drives the clamp input of every cluster output clamp cell, so cluster outputs are forced low whenever the domain is not fully on.

---
 rtl/cluster_pwr_pkg.sv | 50 +++++
 rtl/cluster_pwr_dly_cnt.sv | 40 ++++
 rtl/cluster_pwr_iso_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cluster_pwr_pkg.sv
// Shared types and the state-to-output decode for the cluster power/isolation sequencer.
package cluster_pwr_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_UP_SW     = 4'd1,
        ST_UP_SETTLE = 4'd2,
        ST_UP_CLK    = 4'd3,
        ST_UP_RST    = 4'd4,
        ST_ON        = 4'd5,
        ST_DN_CLAMP  = 4'd6,
        ST_DN_GATE   = 4'd7,
        ST_DN_SW     = 4'd8
    } cluster_pwr_state_e;

    typedef struct packed {
        logic clamp;
        logic clk_en;
        logic rst_n;
        logic sw_en;
    } cluster_pwr_out_t;

    // Output levels held in the domain-off condition (also the reset values).
    localparam cluster_pwr_out_t CLUSTER_PWR_OUT_OFF = '{clamp: 1'b1, clk_en: 1'b0, rst_n: 1'b0, sw_en: 1'b0};

    // Per-state clamp/clk_en/rst_n/sw_en levels; unknown encodings fall back to fully off.
    function automatic cluster_pwr_out_t cluster_pwr_decode(input cluster_pwr_state_e st);
        cluster_pwr_out_t o;
        o = CLUSTER_PWR_OUT_OFF;
        case (st)
            ST_OFF:       o = '{clamp: 1'b1, clk_en: 1'b0, rst_n: 1'b0, sw_en: 1'b0};
            ST_UP_SW:     o = '{clamp: 1'b1, clk_en: 1'b0, rst_n: 1'b0, sw_en: 1'b1};
            ST_UP_SETTLE: o = '{clamp: 1'b1, clk_en: 1'b0, rst_n: 1'b0, sw_en: 1'b1};
            ST_UP_CLK:    o = '{clamp: 1'b1, clk_en: 1'b1, rst_n: 1'b0, sw_en: 1'b1};
            ST_UP_RST:    o = '{clamp: 1'b1, clk_en: 1'b1, rst_n: 1'b1, sw_en: 1'b1};
            ST_ON:        o = '{clamp: 1'b0, clk_en: 1'b1, rst_n: 1'b1, sw_en: 1'b1};
            ST_DN_CLAMP:  o = '{clamp: 1'b1, clk_en: 1'b1, rst_n: 1'b1, sw_en: 1'b1};
            ST_DN_GATE:   o = '{clamp: 1'b1, clk_en: 1'b0, rst_n: 1'b0, sw_en: 1'b1};
            ST_DN_SW:     o = '{clamp: 1'b1, clk_en: 1'b0, rst_n: 1'b0, sw_en: 1'b0};
            default:      o = CLUSTER_PWR_OUT_OFF;
        endcase
        return o;
    endfunction

    // True for every state that belongs to a sequence in progress.
    function automatic logic cluster_pwr_is_busy(input cluster_pwr_state_e st);
        return (st != ST_OFF) && (st != ST_ON);
    endfunction

endpackage

// File: rtl/cluster_pwr_dly_cnt.sv
// Loadable down-counter with a registered done pulse.
// Loading N makes done_o high during the N-th cycle after the load edge,
// so a state that loads on entry and leaves on done_o lasts exactly N cycles.
module cluster_pwr_dly_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q;

    // Next count: load wins, otherwise run down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register and done flag (done tracks count == 1).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == WIDTH'(1));
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/cluster_pwr_iso_ctrl.sv
// Power-up/power-down sequencer for one switchable cluster domain: drives the
// output clamps, clock gate, cluster reset and power-switch chain.
// Optional feature macro: CLUSTER_PWR_ISO_TIMEOUT_EN (power-switch ack timeout
// with sticky err_o; without it the switch states wait forever and err_o is 0).
module cluster_pwr_iso_ctrl
    import cluster_pwr_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_req_i,
    output logic pwr_ack_o,
    output logic busy_o,
    output logic clamp_o,
    output logic clk_en_o,
    output logic cluster_rst_no,
    output logic pwr_sw_en_o,
    input  logic pwr_sw_ack_i,
    output logic err_o
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    // Reject out-of-range configurations at elaboration.
    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cluster_pwr_iso_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    cluster_pwr_state_e state_q, state_d;
    cluster_pwr_out_t   out_d;
    logic               entry_c;
    logic               settle_done;
    logic               req_ok_c;
    logic               clamp_q, clk_en_q, rst_n_q, sw_en_q, ack_q, busy_q;

    // Any state change reloads the settle counter so timed states start fresh.
    assign entry_c = (state_d != state_q);

    cluster_pwr_dly_cnt #(
        .WIDTH (SETTLE_W)
    ) u_settle_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (entry_c),
        .load_val_i (SETTLE_W'(SETTLE_CYCLES)),
        .done_o     (settle_done)
    );

`ifdef CLUSTER_PWR_ISO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic err_q;
    logic tmo_done;
    logic tmo_load_c;
    logic tmo_fire_c;

    // Timeout window restarts on entry to either switch-wait state.
    assign tmo_load_c = entry_c && ((state_d == ST_UP_SW) || (state_d == ST_DN_SW));

    cluster_pwr_dly_cnt #(
        .WIDTH (TMO_W)
    ) u_tmo_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmo_load_c),
        .load_val_i (TMO_W'(TIMEOUT_CYCLES)),
        .done_o     (tmo_done)
    );

    // Timeout fires only while still waiting for the expected ack level.
    assign tmo_fire_c = tmo_done &&
                        (((state_q == ST_UP_SW) && !pwr_sw_ack_i) ||
                         ((state_q == ST_DN_SW) &&  pwr_sw_ack_i));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (tmo_fire_c) begin
            err_q <= 1'b1;
        end
    end

    assign req_ok_c = !err_q;
    assign err_o    = err_q;
`else
    assign req_ok_c = 1'b1;
    assign err_o    = 1'b0;
`endif

    // Next-state decode; the request is only looked at in OFF and ON.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:       if (pwr_req_i && req_ok_c) state_d = ST_UP_SW;
            ST_UP_SW: begin
                if (pwr_sw_ack_i) begin
                    state_d = ST_UP_SETTLE;
                end
`ifdef CLUSTER_PWR_ISO_TIMEOUT_EN
                else if (tmo_fire_c) begin
                    state_d = ST_OFF;
                end
`endif
            end
            ST_UP_SETTLE: if (settle_done) state_d = ST_UP_CLK;
            ST_UP_CLK:    if (settle_done) state_d = ST_UP_RST;
            ST_UP_RST:    state_d = ST_ON;
            ST_ON:        if (!pwr_req_i) state_d = ST_DN_CLAMP;
            ST_DN_CLAMP:  if (settle_done) state_d = ST_DN_GATE;
            ST_DN_GATE:   state_d = ST_DN_SW;
            ST_DN_SW: begin
                if (!pwr_sw_ack_i) begin
                    state_d = ST_OFF;
                end
`ifdef CLUSTER_PWR_ISO_TIMEOUT_EN
                else if (tmo_fire_c) begin
                    state_d = ST_OFF;
                end
`endif
            end
            default:      state_d = ST_OFF;
        endcase
    end

    assign out_d = cluster_pwr_decode(state_d);

    // State and output flops loaded from the next-state decode (glitch-free outputs).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_OFF;
            clamp_q  <= 1'b1;
            clk_en_q <= 1'b0;
            rst_n_q  <= 1'b0;
            sw_en_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clamp_q  <= out_d.clamp;
            clk_en_q <= out_d.clk_en;
            rst_n_q  <= out_d.rst_n;
            sw_en_q  <= out_d.sw_en;
            ack_q    <= (state_d == ST_ON);
            busy_q   <= cluster_pwr_is_busy(state_d);
        end
    end

    assign clamp_o        = clamp_q;
    assign clk_en_o       = clk_en_q;
    assign cluster_rst_no = rst_n_q;
    assign pwr_sw_en_o    = sw_en_q;
    assign pwr_ack_o      = ack_q;
    assign busy_o         = busy_q;

endmodule
